// File: rtl/pipefft_pkg.sv
// pipefft_pkg: shared constants and elaboration helpers for the pipelined FFT delay lines
package pipefft_pkg;
  localparam int MRAM_RD_LAT = 2;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  function automatic bit delay_ok(input int dly, input int aw);
    return dly >= 1 && dly <= depth_of(aw) - 1;
  endfunction
endpackage

// File: rtl/pipefft_vshift.sv
// pipefft_vshift: clearable N-stage valid-strobe shift register
module pipefft_vshift #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr_q, sr_d;
  always_comb sr_d = clr ? '0 : N'({sr_q, d});
  always_ff @(posedge clk) sr_q <= rst ? '0 : sr_d;
  assign q = sr_q[N-1];
endmodule

// File: rtl/pipefft_dly_ctrl.sv
// pipefft_dly_ctrl: drives a small micro-RAM as a fixed DELAY-valid-sample delay line
module pipefft_dly_ctrl
  import pipefft_pkg::*;
#(
  parameter int WIDTH  = 68,
  parameter int AWIDTH = 2,
  parameter int DELAY  = 3,
  parameter int RD_LAT = MRAM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [AWIDTH:0]   fill,
  output logic              ram_wEn,
  output logic [AWIDTH-1:0] ram_wAddr,
  output logic [WIDTH-1:0]  ram_wD,
  output logic [AWIDTH-1:0] ram_rAddr,
  input  logic [WIDTH-1:0]  ram_rD
);
  localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(DELAY);
  if (!delay_ok(DELAY, AWIDTH)) begin : g_bad_delay
    $error("pipefft_dly_ctrl: DELAY must lie in 1..DEPTH-1");
  end
  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH:0]   fill_q, fill_d;
  logic              primed;
  always_comb begin
    primed = fill_q == FULL;
    wptr_d = in_valid ? wptr_q + AWIDTH'(1) : wptr_q;
    fill_d = flush ? {AWIDTH'(0), in_valid} : (in_valid && !primed) ? fill_q + (AWIDTH+1)'(1) : fill_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
    end
  end
  // read address trails the write pointer, so it never collides with the write
  assign ram_wEn   = in_valid & ~rst;
  assign ram_wAddr = wptr_q;
  assign ram_wD    = in_data;
  assign ram_rAddr = wptr_q - AWIDTH'(DELAY);
  assign out_data  = ram_rD;
  assign fill      = fill_q;
  pipefft_vshift #(.N(RD_LAT)) u_vshift (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .d  (in_valid & primed),
    .q  (out_valid)
  );
endmodule
